io_port_hub: RTL and testbench

- Parametrised port-mapped I/O hub between the RAT MCU bus (PORT_ID / OUT_PORT / IN_PORT / IO_STRB) and board peripherals.
- Replaces hand-written per-device if/else muxes with:
  - NUM_IN synchronised input channels;
  - NUM_OUT strobed output registers;
  - an 8-source edge-captured interrupt controller with mask and acknowledge registers.
- Drives the MCU interrupt line.

---
 rtl/io_port_hub_if.sv | 29 ++
 rtl/io_port_hub.sv | 136 +++++++++++++
 tb/tb_io_port_hub.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_hub_if.sv
// +----------------------------------------------------------------------------+
// | io_port_hub_if : RAT MCU port-mapped I/O bus (address, write data/strobe,  |
// |                  combinational read data)                                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface io_port_hub_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_PORT
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_PORT
  );
endinterface

`default_nettype wire

// File: rtl/io_port_hub.sv
// +----------------------------------------------------------------------------+
// | io_port_hub : synchronised input channels, strobed output registers and an |
// |               8-source edge-captured interrupt controller for the RAT MCU  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module io_port_hub #(
  parameter int         NUM_IN        = 8,
  parameter int         NUM_OUT       = 4,
  parameter logic [7:0] IN_BASE_ID    = 8'h90,
  parameter logic [7:0] OUT_BASE_ID   = 8'h40,
  parameter logic [7:0] IRQ_STATUS_ID = 8'hF0,
  parameter logic [7:0] IRQ_MASK_ID   = 8'hF1,
  parameter logic [7:0] IRQ_ACK_ID    = 8'hF2,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  io_port_hub_if.slave         bus,
  input  logic [NUM_IN*8-1:0]  IN_DATA,
  output logic [NUM_OUT*8-1:0] OUT_DATA,
  output logic [NUM_OUT-1:0]   OUT_WE,
  input  logic [7:0]           IRQ_SRC,
  output logic                 INTERRUPT
);

  localparam int c_last_stage = SYNC_STAGES - 1;

  logic [NUM_IN*8-1:0]  r_in_sync  [SYNC_STAGES];
  logic [7:0]           r_irq_sync [SYNC_STAGES];
  logic [7:0]           r_irq_prev;
  logic [7:0]           r_mask;
  logic [7:0]           r_pending;
  logic                 r_interrupt;
  logic [NUM_OUT*8-1:0] r_out_data;
  logic [NUM_OUT-1:0]   r_out_we;

  logic [NUM_IN*8-1:0]  w_in_last;
  logic [NUM_OUT-1:0]   w_out_hit;
  logic                 w_mask_wr;
  logic                 w_ack_wr;
  logic [7:0]           w_irq_edge;
  logic [7:0]           w_ack_clr;
  logic [7:0]           w_rd_data;

  // Synchroniser chains for the asynchronous data and interrupt inputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_in_sync[s]  <= '0;
        r_irq_sync[s] <= '0;
      end
    end else begin
      r_in_sync[0]  <= IN_DATA;
      r_irq_sync[0] <= IRQ_SRC;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_in_sync[s]  <= r_in_sync[s-1];
        r_irq_sync[s] <= r_irq_sync[s-1];
      end
    end
  end

  assign w_in_last = r_in_sync[c_last_stage];

  // Write address decode
  generate
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_dec
      localparam logic [7:0] c_out_id = 8'(OUT_BASE_ID + j);
      assign w_out_hit[j] = bus.IO_STRB && (bus.PORT_ID == c_out_id);
    end
  endgenerate

  assign w_mask_wr = bus.IO_STRB && (bus.PORT_ID == IRQ_MASK_ID);
  assign w_ack_wr  = bus.IO_STRB && (bus.PORT_ID == IRQ_ACK_ID);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_data <= '0;
      r_out_we   <= '0;
    end else begin
      r_out_we <= w_out_hit;
      for (int j = 0; j < NUM_OUT; j++) begin
        if (w_out_hit[j]) begin
          r_out_data[8*j +: 8] <= bus.OUT_PORT;
        end
      end
    end
  end

  // Edge sets take precedence over a same-cycle acknowledge of that bit
  assign w_irq_edge = r_irq_sync[c_last_stage] & ~r_irq_prev;
  assign w_ack_clr  = w_ack_wr ? bus.OUT_PORT : 8'h00;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_irq_prev  <= '0;
      r_mask      <= '0;
      r_pending   <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_irq_prev  <= r_irq_sync[c_last_stage];
      r_pending   <= (r_pending & ~w_ack_clr) | w_irq_edge;
      r_interrupt <= |(r_pending & r_mask);
      if (w_mask_wr) begin
        r_mask <= bus.OUT_PORT;
      end
    end
  end

  // Read mux: IRQ registers shadow any overlapping input channel ID
  always_comb begin
    w_rd_data = 8'h00;
    if (bus.PORT_ID == IRQ_STATUS_ID) begin
      w_rd_data = r_pending;
    end else if (bus.PORT_ID == IRQ_MASK_ID) begin
      w_rd_data = r_mask;
    end else if (bus.PORT_ID == IRQ_ACK_ID) begin
      w_rd_data = 8'h00;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.PORT_ID == 8'(IN_BASE_ID + i)) begin
          w_rd_data = w_in_last[8*i +: 8];
        end
      end
    end
  end

  assign bus.IN_PORT = w_rd_data;
  assign OUT_DATA    = r_out_data;
  assign OUT_WE      = r_out_we;
  assign INTERRUPT   = r_interrupt;

endmodule

`default_nettype wire

// File: tb/tb_io_port_hub.sv
// +----------------------------------------------------------------------------+
// | tb_io_port_hub : directed self-checking bench for io_port_hub              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_io_port_hub;

  logic        CLK;
  logic        RESET_N;
  logic [63:0] IN_DATA;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_WE;
  logic [7:0]  IRQ_SRC;
  logic        INTERRUPT;

  int total;
  int bad;

  io_port_hub_if bus ();

  io_port_hub dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_WE    (OUT_WE),
    .IRQ_SRC   (IRQ_SRC),
    .INTERRUPT (INTERRUPT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    bus.PORT_ID = id;
    #1;
    d = bus.IN_PORT;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tick();
    tick();
    total++; if (OUT_DATA !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=%h", OUT_DATA, 32'h0); end
    total++; if (OUT_WE !== 4'h0) begin bad++; $display("FAIL rst_out_we got=%b exp=%b", OUT_WE, 4'h0); end
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL rst_interrupt got=%b exp=0", INTERRUPT); end
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h exp=00", d); end
    rd(8'hF1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_mask got=%h exp=00", d); end
    RESET_N = 1'b1;
  endtask

  task automatic test_input_sync();
    logic [7:0] d;
    IN_DATA[31:24] = 8'hA5;
    IN_DATA[63:56] = 8'h5A;
    rd(8'h93, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL in_ch3_e0 got=%h exp=00", d); end
    tick();
    rd(8'h93, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL in_ch3_e1 got=%h exp=00", d); end
    tick();
    rd(8'h93, d);
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL in_ch3_e2 got=%h exp=a5", d); end
    rd(8'h97, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL in_ch7 got=%h exp=5a", d); end
    rd(8'h90, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL in_ch0 got=%h exp=00", d); end
    rd(8'h98, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL in_unmapped got=%h exp=00", d); end
  endtask

  task automatic test_output();
    logic [7:0] d;
    wr(8'h42, 8'h3C);
    total++; if (OUT_DATA !== 32'h003C0000) begin bad++; $display("FAIL out_data got=%h exp=%h", OUT_DATA, 32'h003C0000); end
    total++; if (OUT_WE !== 4'b0100) begin bad++; $display("FAIL out_we_pulse got=%b exp=0100", OUT_WE); end
    tick();
    total++; if (OUT_WE !== 4'b0000) begin bad++; $display("FAIL out_we_end got=%b exp=0000", OUT_WE); end
    bus.PORT_ID  = 8'h42;
    bus.OUT_PORT = 8'hFF;
    tick();
    total++; if (OUT_DATA !== 32'h003C0000) begin bad++; $display("FAIL out_nostrb got=%h exp=%h", OUT_DATA, 32'h003C0000); end
    wr(8'h44, 8'hEE);
    total++; if (OUT_DATA !== 32'h003C0000 || OUT_WE !== 4'b0000) begin bad++; $display("FAIL out_unmapped got=%h/%b exp=%h/0000", OUT_DATA, OUT_WE, 32'h003C0000); end
    rd(8'h42, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL out_not_readable got=%h exp=00", d); end
  endtask

  task automatic test_back_to_back();
    bus.PORT_ID  = 8'h40;
    bus.OUT_PORT = 8'h11;
    bus.IO_STRB  = 1'b1;
    tick();
    total++; if (OUT_WE !== 4'b0001 || OUT_DATA[7:0] !== 8'h11) begin bad++; $display("FAIL b2b_first got=%b/%h exp=0001/11", OUT_WE, OUT_DATA[7:0]); end
    bus.OUT_PORT = 8'h22;
    tick();
    total++; if (OUT_WE !== 4'b0001 || OUT_DATA[7:0] !== 8'h22) begin bad++; $display("FAIL b2b_second got=%b/%h exp=0001/22", OUT_WE, OUT_DATA[7:0]); end
    bus.PORT_ID  = 8'h43;
    bus.OUT_PORT = 8'h99;
    tick();
    bus.IO_STRB  = 1'b0;
    total++; if (OUT_WE !== 4'b1000) begin bad++; $display("FAIL b2b_reg3_we got=%b exp=1000", OUT_WE); end
    tick();
    total++; if (OUT_WE !== 4'b0000) begin bad++; $display("FAIL b2b_we_end got=%b exp=0000", OUT_WE); end
    total++; if (OUT_DATA !== 32'h993C0022) begin bad++; $display("FAIL b2b_data got=%h exp=%h", OUT_DATA, 32'h993C0022); end
  endtask

  task automatic test_irq_basic();
    logic [7:0] d;
    wr(8'hF1, 8'h05);
    rd(8'hF1, d);
    total++; if (d !== 8'h05) begin bad++; $display("FAIL irq_mask_rd got=%h exp=05", d); end
    IRQ_SRC = 8'h04;
    tick();
    IRQ_SRC = 8'h00;
    tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL irq_pend_early got=%h exp=00", d); end
    tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL irq_pend_set got=%h exp=04", d); end
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL irq_int_early got=%b exp=0", INTERRUPT); end
    tick();
    total++; if (INTERRUPT !== 1'b1) begin bad++; $display("FAIL irq_int_high got=%b exp=1", INTERRUPT); end
    rd(8'hF2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL irq_ack_rd got=%h exp=00", d); end
    wr(8'hF2, 8'h04);
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL irq_pend_ack got=%h exp=00", d); end
    tick();
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL irq_int_clear got=%b exp=0", INTERRUPT); end
  endtask

  task automatic test_irq_masked();
    logic [7:0] d;
    wr(8'hF1, 8'h00);
    IRQ_SRC = 8'h80;
    tick();
    IRQ_SRC = 8'h00;
    tick();
    tick();
    tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL mask_pend got=%h exp=80", d); end
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL mask_int_low got=%b exp=0", INTERRUPT); end
    wr(8'hF1, 8'h80);
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL mask_int_wait got=%b exp=0", INTERRUPT); end
    tick();
    total++; if (INTERRUPT !== 1'b1) begin bad++; $display("FAIL mask_unmask_int got=%b exp=1", INTERRUPT); end
    wr(8'hF2, 8'h80);
    tick();
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL mask_ack_int got=%b exp=0", INTERRUPT); end
  endtask

  task automatic test_set_ack_collision();
    logic [7:0] d;
    logic       extra;
    IRQ_SRC = 8'h02;
    tick();
    tick();
    wr(8'hF2, 8'h02);
    rd(8'hF0, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL coll_set_wins got=%h exp=02", d); end
    wr(8'hF2, 8'h02);
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL coll_ack got=%h exp=00", d); end
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      rd(8'hF0, d);
      if (d !== 8'h00) extra = 1'b1;
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL coll_level_reset got=%b exp=0", extra); end
    IRQ_SRC = 8'h00;
  endtask

  task automatic test_reset_midop();
    logic [7:0] d;
    wr(8'hF1, 8'hFF);
    IRQ_SRC = 8'h01;
    tick();
    IRQ_SRC = 8'h00;
    tick();
    tick();
    tick();
    total++; if (INTERRUPT !== 1'b1) begin bad++; $display("FAIL rmid_int_pre got=%b exp=1", INTERRUPT); end
    bus.PORT_ID  = 8'h41;
    bus.OUT_PORT = 8'h77;
    bus.IO_STRB  = 1'b1;
    IRQ_SRC      = 8'h08;
    tick();
    bus.IO_STRB  = 1'b0;
    IRQ_SRC      = 8'h00;
    total++; if (OUT_WE !== 4'b0010) begin bad++; $display("FAIL rmid_we_pre got=%b exp=0010", OUT_WE); end
    #2;
    RESET_N = 1'b0;
    #1;
    total++; if (OUT_DATA !== 32'h0) begin bad++; $display("FAIL rmid_out_data got=%h exp=%h", OUT_DATA, 32'h0); end
    total++; if (OUT_WE !== 4'h0) begin bad++; $display("FAIL rmid_out_we got=%b exp=0000", OUT_WE); end
    total++; if (INTERRUPT !== 1'b0) begin bad++; $display("FAIL rmid_int got=%b exp=0", INTERRUPT); end
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rmid_pending got=%h exp=00", d); end
    rd(8'hF1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rmid_mask got=%h exp=00", d); end
    rd(8'h10, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rmid_unmapped got=%h exp=00", d); end
    tick();
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rmid_pipe_flushed got=%h exp=00", d); end
    // A source already high across reset release yields one edge
    RESET_N = 1'b0;
    IRQ_SRC = 8'h10;
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rel_high_early got=%h exp=00", d); end
    tick();
    rd(8'hF0, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL rel_high_set got=%h exp=10", d); end
    IRQ_SRC = 8'h00;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    RESET_N      = 1'b0;
    IN_DATA      = '0;
    IRQ_SRC      = 8'h00;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    test_reset();
    test_input_sync();
    test_output();
    test_back_to_back();
    test_irq_basic();
    test_irq_masked();
    test_set_ack_collision();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
